// File: rtl/alu_pkg.sv
// alu_pkg: constants, opcode encodings and FSM state encoding shared by the
// ALU command driver and its flag generator.
//   ALU_DATA_W / ALU_OP_W : ALU datapath and opcode widths
//   ALU_OP_*              : opcode encodings understood by the ALU
//   drv_state_e           : driver FSM states (DRV_IDLE / DRV_DRIVE / DRV_RESP)
//   alu_op_legal()        : 1 when the opcode is one the ALU implements
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_OP_W   = 3;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    DRV_IDLE  = 2'd0,
    DRV_DRIVE = 2'd1,
    DRV_RESP  = 2'd2
  } drv_state_e;

  // Opcodes 101..111 have no ALU function behind them.
  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    return (op <= ALU_OP_NOT);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational status flags for one ALU operation.
//   i_op     : opcode held on the ALU
//   i_a, i_b : operands held on the ALU
//   i_result : ALU RESULT for those operands
//   o_zero   : result is all zeros
//   o_carry  : carry-out of ADD, borrow of SUB (a < b); 0 for other ops
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [ALU_OP_W-1:0] i_op,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  input  logic [DATA_W-1:0]   i_result,
  output logic                o_zero,
  output logic                o_carry
);

  logic [DATA_W-1:0] w_sum;

  // A wrapped sum is smaller than an addend exactly when the add carried out.
  assign w_sum  = i_a + i_b;
  assign o_zero = (i_result == {DATA_W{1'b0}});

  // Carry/borrow selection by opcode.
  always_comb begin
    o_carry = 1'b0;
    case (i_op)
      ALU_OP_ADD: o_carry = (w_sum < i_a);
      ALU_OP_SUB: o_carry = (i_a < i_b);
      default:    o_carry = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: initiator for an 8-bit combinational ALU. Accepts one
// command at a time, holds registered operands/opcode on the ALU for
// SETTLE_CYCLES cycles, captures RESULT and returns it on a response channel.
// An accumulator keeps the last legal result for chained operations.
//   clk, rst_n                      : clock, async active-low reset
//   cmd_valid/cmd_ready             : command handshake
//   cmd_op, cmd_a, cmd_b, cmd_use_acc : command payload
//   alu_a, alu_b, alu_sel           : registered drive to the ALU
//   alu_result                      : ALU RESULT
//   rsp_valid/rsp_ready             : response handshake
//   rsp_data, rsp_err               : captured result, illegal-opcode flag
//   acc                             : accumulator
// Optional macro ALU_DRV_FLAGS_EN adds rsp_zero and rsp_carry outputs.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DATA_W        = ALU_DATA_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ALU_OP_W-1:0] cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic                cmd_use_acc,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [ALU_OP_W-1:0] alu_sel,
  input  logic [DATA_W-1:0]   alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   acc
`ifdef ALU_DRV_FLAGS_EN
  ,
  output logic                rsp_zero,
  output logic                rsp_carry
`endif
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  drv_state_e          r_state;
  drv_state_e          w_next_state;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [ALU_OP_W-1:0] r_alu_sel;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_acc;
  logic                w_cmd_ready;
  logic                w_rsp_valid;
  logic                w_accept;
  logic                w_op_legal;
  logic                w_settle_done;

  assign w_accept      = cmd_valid & w_cmd_ready;
  assign w_op_legal    = alu_op_legal(cmd_op);
  assign w_settle_done = (r_cnt == 4'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DRV_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; illegal opcodes skip DRIVE entirely.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DRV_IDLE: begin
        if (w_accept) begin
          w_next_state = w_op_legal ? DRV_DRIVE : DRV_RESP;
        end else begin
          w_next_state = DRV_IDLE;
        end
      end
      DRV_DRIVE: begin
        if (w_settle_done) begin
          w_next_state = DRV_RESP;
        end else begin
          w_next_state = DRV_DRIVE;
        end
      end
      DRV_RESP: begin
        if (rsp_ready) begin
          w_next_state = DRV_IDLE;
        end else begin
          w_next_state = DRV_RESP;
        end
      end
      default: w_next_state = DRV_IDLE;
    endcase
  end

  // Handshake outputs; rst_n gates cmd_ready so it is low throughout reset.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      DRV_IDLE:  w_cmd_ready = rst_n;
      DRV_RESP:  w_rsp_valid = 1'b1;
      default: begin
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
      end
    endcase
  end

  // Datapath: ALU drive registers, settle counter, response and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_alu_a    <= {DATA_W{1'b0}};
      r_alu_b    <= {DATA_W{1'b0}};
      r_alu_sel  <= ALU_OP_ADD;
      r_rsp_data <= {DATA_W{1'b0}};
      r_rsp_err  <= 1'b0;
      r_acc      <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        DRV_IDLE: begin
          if (w_accept) begin
            if (w_op_legal) begin
              r_alu_a   <= cmd_use_acc ? r_acc : cmd_a;
              r_alu_b   <= cmd_b;
              r_alu_sel <= cmd_op;
              r_cnt     <= SETTLE_LOAD;
            end else begin
              r_rsp_data <= {DATA_W{1'b0}};
              r_rsp_err  <= 1'b1;
            end
          end
        end
        DRV_DRIVE: begin
          if (w_settle_done) begin
            r_rsp_data <= alu_result;
            r_acc      <= alu_result;
            r_rsp_err  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = w_rsp_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign acc       = r_acc;

`ifdef ALU_DRV_FLAGS_EN
  logic w_zero;
  logic w_carry;
  logic r_rsp_zero;
  logic r_rsp_carry;

  alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .i_op     (r_alu_sel),
    .i_a      (r_alu_a),
    .i_b      (r_alu_b),
    .i_result (alu_result),
    .o_zero   (w_zero),
    .o_carry  (w_carry)
  );

  // Flags are captured alongside rsp_data; an illegal op reports data 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
    end else if ((r_state == DRV_IDLE) && w_accept && !w_op_legal) begin
      r_rsp_zero  <= 1'b1;
      r_rsp_carry <= 1'b0;
    end else if ((r_state == DRV_DRIVE) && w_settle_done) begin
      r_rsp_zero  <= w_zero;
      r_rsp_carry <= w_carry;
    end
  end

  assign rsp_zero  = r_rsp_zero;
  assign rsp_carry = r_rsp_carry;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: two driver instances (SETTLE_CYCLES 1 and 4), each
// feeding a behavioural 8-bit ALU. Table-driven commands with a scoreboard
// queue, plus hand-written backpressure and mid-DRIVE reset sequences.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid   [2];
  logic       cmd_ready   [2];
  logic [2:0] cmd_op      [2];
  logic [7:0] cmd_a       [2];
  logic [7:0] cmd_b       [2];
  logic       cmd_use_acc [2];
  logic [7:0] alu_a       [2];
  logic [7:0] alu_b       [2];
  logic [2:0] alu_sel     [2];
  logic [7:0] alu_result  [2];
  logic       rsp_valid   [2];
  logic       rsp_ready   [2];
  logic [7:0] rsp_data    [2];
  logic       rsp_err     [2];
  logic [7:0] acc         [2];
`ifdef ALU_DRV_FLAGS_EN
  logic       rsp_zero    [2];
  logic       rsp_carry   [2];
`endif

  typedef struct {
    int         idx;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic [7:0] exp_data;
    logic       exp_err;
    logic       exp_c;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
    logic       c;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[11];
  int         n_checks;
  int         n_errors;
  logic [7:0] m_acc [2];
  logic [7:0] m_a   [2];
  logic [7:0] m_b   [2];
  logic [2:0] m_sel [2];

  // Behavioural ALU standing in for the real downstream block.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result[0] = alu_f(alu_a[0], alu_b[0], alu_sel[0]);
  assign alu_result[1] = alu_f(alu_a[1], alu_b[1], alu_sel[1]);

  alu_cmd_driver #(.DATA_W(8), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_use_acc(cmd_use_acc[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]), .alu_result(alu_result[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .acc(acc[0])
`ifdef ALU_DRV_FLAGS_EN
    , .rsp_zero(rsp_zero[0]), .rsp_carry(rsp_carry[0])
`endif
  );

  alu_cmd_driver #(.DATA_W(8), .SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_use_acc(cmd_use_acc[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]), .alu_result(alu_result[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .acc(acc[1])
`ifdef ALU_DRV_FLAGS_EN
    , .rsp_zero(rsp_zero[1]), .rsp_carry(rsp_carry[1])
`endif
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 8'h00;
      m_a[i]   = 8'h00;
      m_b[i]   = 8'h00;
      m_sel[i] = 3'b000;
    end
  endtask

  // One command through instance idx; hold = cycles rsp_ready stays low.
  task automatic do_op(input int idx, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic use_acc, input logic [7:0] exp_data,
                       input logic exp_err, input logic exp_c, input int hold);
    exp_t e;
    int   lat;
    int   exp_lat;
    exp_lat = exp_err ? 0 : ((idx == 0) ? 1 : 4);
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready[idx]}, 32'd1);
    cmd_op[idx]      = op;
    cmd_a[idx]       = a;
    cmd_b[idx]       = b;
    cmd_use_acc[idx] = use_acc;
    cmd_valid[idx]   = 1'b1;
    rsp_ready[idx]   = (hold == 0);
    sb.push_back('{d: exp_data, e: exp_err, c: exp_c});
    if (!exp_err) begin
      m_a[idx]   = use_acc ? m_acc[idx] : a;
      m_b[idx]   = b;
      m_sel[idx] = op;
    end
    @(posedge clk);
    #1;
    cmd_valid[idx] = 1'b0;
    chk("alu_a_issue", {24'd0, alu_a[idx]}, {24'd0, m_a[idx]});
    chk("alu_b_issue", {24'd0, alu_b[idx]}, {24'd0, m_b[idx]});
    chk("alu_sel_issue", {29'd0, alu_sel[idx]}, {29'd0, m_sel[idx]});
    lat = 0;
    while (!rsp_valid[idx] && lat < 20) begin
      chk("alu_sel_stable", {29'd0, alu_sel[idx]}, {29'd0, m_sel[idx]});
      chk("alu_a_stable", {24'd0, alu_a[idx]}, {24'd0, m_a[idx]});
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_latency", lat, exp_lat);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (!e.e) m_acc[idx] = e.d;
      chk("rsp_data", {24'd0, rsp_data[idx]}, {24'd0, e.d});
      chk("rsp_err", {31'd0, rsp_err[idx]}, {31'd0, e.e});
      chk("acc", {24'd0, acc[idx]}, {24'd0, m_acc[idx]});
      chk("alu_sel_hold", {29'd0, alu_sel[idx]}, {29'd0, m_sel[idx]});
`ifdef ALU_DRV_FLAGS_EN
      chk("rsp_carry", {31'd0, rsp_carry[idx]}, {31'd0, e.c});
      chk("rsp_zero", {31'd0, rsp_zero[idx]}, {31'd0, (e.d == 8'h00)});
`endif
      // Backpressure: a competing command is offered but must not be taken.
      for (int h = 0; h < hold; h++) begin
        cmd_op[idx]    = ALU_OP_OR;
        cmd_a[idx]     = 8'hAA;
        cmd_valid[idx] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rsp_valid", {31'd0, rsp_valid[idx]}, 32'd1);
        chk("bp_rsp_data", {24'd0, rsp_data[idx]}, {24'd0, e.d});
        chk("bp_cmd_ready", {31'd0, cmd_ready[idx]}, 32'd0);
        chk("bp_alu_a", {24'd0, alu_a[idx]}, {24'd0, m_a[idx]});
      end
    end
    cmd_valid[idx] = 1'b0;
    rsp_ready[idx] = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_valid_drop", {31'd0, rsp_valid[idx]}, 32'd0);
    chk("cmd_ready_back", {31'd0, cmd_ready[idx]}, 32'd1);
    rsp_ready[idx] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i]   = 1'b0;
      cmd_op[i]      = 3'b000;
      cmd_a[i]       = 8'h00;
      cmd_b[i]       = 8'h00;
      cmd_use_acc[i] = 1'b0;
      rsp_ready[i]   = 1'b0;
    end

    //             idx op          a      b      acc   data   err   carry
    vecs[0]  = '{0, ALU_OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{0, ALU_OP_SUB, 8'h10, 8'h03, 1'b0, 8'h0D, 1'b0, 1'b0};
    vecs[2]  = '{0, ALU_OP_OR,  8'h55, 8'hF0, 1'b1, 8'hFD, 1'b0, 1'b0};
    vecs[3]  = '{0, ALU_OP_NOT, 8'h77, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0};
    vecs[4]  = '{0, 3'b110,     8'h12, 8'h34, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{0, ALU_OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[6]  = '{0, ALU_OP_AND, 8'h00, 8'h0F, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[7]  = '{0, 3'b111,     8'h9A, 8'hBC, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{0, ALU_OP_ADD, 8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[9]  = '{1, ALU_OP_AND, 8'hAC, 8'h3F, 1'b0, 8'h2C, 1'b0, 1'b0};
    vecs[10] = '{1, ALU_OP_ADD, 8'h00, 8'h10, 1'b1, 8'h3C, 1'b0, 1'b0};

    // Reset state.
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmd_ready", {31'd0, cmd_ready[i]}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
      chk("rst_rsp_data", {24'd0, rsp_data[i]}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err[i]}, 32'd0);
      chk("rst_alu_sel", {29'd0, alu_sel[i]}, 32'd0);
      chk("rst_acc", {24'd0, acc[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", {31'd0, cmd_ready[0]}, 32'd1);
    chk("post_rst_ready1", {31'd0, cmd_ready[1]}, 32'd1);

    for (int v = 0; v < 11; v++) begin
      do_op(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].use_acc,
            vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_c, 0);
    end

    // Backpressure: response held off for 5 cycles.
    do_op(0, ALU_OP_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 5);
    do_op(0, ALU_OP_OR, 8'h0F, 8'h30, 1'b0, 8'h3F, 1'b0, 1'b0, 0);

    // Reset while the SETTLE_CYCLES=4 instance is in DRIVE.
    @(negedge clk);
    cmd_op[1]      = ALU_OP_ADD;
    cmd_a[1]       = 8'h01;
    cmd_b[1]       = 8'h01;
    cmd_use_acc[1] = 1'b0;
    cmd_valid[1]   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    chk("mid_rst_alu_sel", {29'd0, alu_sel[1]}, 32'd0);
    chk("mid_rst_alu_a", {24'd0, alu_a[1]}, 32'd0);
    chk("mid_rst_acc1", {24'd0, acc[1]}, 32'd0);
    chk("mid_rst_acc0", {24'd0, acc[0]}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_release_ready", {31'd0, cmd_ready[1]}, 32'd1);
    do_op(1, ALU_OP_ADD, 8'h05, 8'h06, 1'b0, 8'h0B, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator side of the 8-bit combinational ALU interface (ALU inputs A, B, SEL; output RESULT). Accepts operation commands over a valid/ready handshake, drives registered operands and opcode onto the ALU, waits a programmable settle time, then captures RESULT. Returns each result over a valid/ready response channel and keeps an accumulator so operations can be chained.

Parameters:
DATA_W, 8, operand/result width; must equal the ALU width (8).
SETTLE_CYCLES, 1, cycles alu_* are held stable before RESULT is sampled; legal 1..15.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept a command
cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT(A)
cmd_a  input  DATA_W  operand A
cmd_b  input  DATA_W  operand B
cmd_use_acc  input  1  1: use the accumulator as operand A instead of cmd_a
alu_a  output  DATA_W  to ALU A (registered)
alu_b  output  DATA_W  to ALU B (registered)
alu_sel  output  3  to ALU SEL (registered)
alu_result  input  DATA_W  from ALU RESULT
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_data  output  DATA_W  captured result
rsp_err  output  1  opcode was illegal (101..111)
acc  output  DATA_W  accumulator, last legal result

Behaviour:
- Reset (async, rst_n=0): state IDLE, cmd_ready=0 while in reset, rsp_valid=0, rsp_data=0, rsp_err=0, alu_a=0, alu_b=0, alu_sel=000, acc=0, settle counter=0. Any in-flight command is dropped. After deassertion, cmd_ready=1 from the first cycle.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge E0:
  - Legal op: load alu_a (acc if cmd_use_acc, else cmd_a), alu_b=cmd_b, alu_sel=cmd_op; counter=SETTLE_CYCLES-1; go to DRIVE.
  - Illegal op: alu_* unchanged; rsp_data=0, rsp_err=1; go to RESP directly. acc is not updated.
- DRIVE: cmd_ready=0; alu_* held stable. If the counter is 0 at an edge, sample alu_result into rsp_data and acc, set rsp_err=0, and go to RESP. Otherwise decrement the counter.
  - Legal-op latency: rsp_valid rises SETTLE_CYCLES edges after E0.
- RESP: rsp_valid=1; rsp_data and rsp_err are stable until the handshake. On rsp_ready go to IDLE (rsp_valid=0 next cycle).
  - No overlap: a new command is accepted only in IDLE. Throughput is one command per SETTLE_CYCLES+2 cycles when rsp_ready is held at 1.
- alu_* outputs hold the last issued values between commands; they are never re-driven in IDLE or RESP.
- Arithmetic is entirely inside the ALU; results wrap modulo 2^DATA_W (e.g. 0xFF+0x01=0x00, 0x00-0x01=0xFF).
- cmd_use_acc samples acc at the accept edge. Back-to-back chained commands therefore see the previous result.
- rsp_ready asserted outside RESP is ignored. cmd_valid outside IDLE is ignored; the command is not lost, because cmd_ready=0 there.

Optional Feature:
Macro ALU_DRV_FLAGS_EN.
- Defined: adds outputs rsp_zero (rsp_data==0) and rsp_carry, both registered with rsp_data.
  - rsp_carry is the carry-out of ADD or the borrow of SUB (alu_a<alu_b), computed locally from the held operands. It is 0 for AND/OR/NOT and for illegal ops.
  - Both flags reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - ALU_DATA_W=8 and ALU_OP_W=3.
  - Opcode constants ALU_OP_ADD/SUB/AND/OR/NOT.
  - Function alu_op_legal(op).
  - State encoding constants DRV_IDLE/DRV_DRIVE/DRV_RESP.
- One natural sub-module: alu_flag_gen (combinational zero/carry from op, operands, result), instantiated only under ALU_DRV_FLAGS_EN.
- The testbench instantiates the existing ALU as the downstream model.

Test Plan:
- Reset: assert rst_n=0 mid-DRIVE -> next cycle rsp_valid=0, alu_sel=000, acc=0, state IDLE; after release cmd_ready=1.
- ADD wrap: cmd_op=000, a=0xFF, b=0x01, rsp_ready=1, SETTLE_CYCLES=1 -> rsp_valid 1 edge after accept, rsp_data=0x00, rsp_err=0, acc=0x00; with flags, rsp_carry=1, rsp_zero=1.
- Chain: SUB a=0x10 b=0x03 -> 0x0D; then use_acc=1 OR b=0xF0 -> 0xFD; then use_acc=1 NOT -> 0x02; acc tracks each result.
- Illegal op: cmd_op=110 -> rsp_valid the edge after accept, rsp_data=0x00, rsp_err=1, acc unchanged, alu_sel unchanged.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_data stable, cmd_ready=0, new cmd_valid not accepted until after the rsp handshake.
- SETTLE_CYCLES=4: AND a=0xAC b=0x3F -> alu_* stable for 4 cycles, rsp_data=0x2C exactly 4 edges after accept.
